// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants and types for the iterative multiply/divide sequencer.
// Holds default widths, FSM state encoding and op-select values.
package multdiv_sequencer_pkg;

  localparam int MD_DATA_W = 32;
  localparam int MD_CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/md_step_unit.sv
// One radix-2 iteration on unsigned magnitudes: LSB-first shift-add multiply
// or restoring-subtract divide. {hi, lo} is the shared product/remainder:quotient pair.
module md_step_unit
  import multdiv_sequencer_pkg::*;
#(
  parameter int W = MD_DATA_W
) (
  input  logic         is_div,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] mag_b,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);

  logic [W:0] mul_sum;
  logic [W:0] div_shift;
  logic [W:0] div_diff;

  always_comb begin
    mul_sum   = lo[0] ? ({1'b0, hi} + {1'b0, mag_b}) : {1'b0, hi};
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    hi_next   = hi;
    lo_next   = lo;
    if (is_div == OP_MUL) begin
      // Carry out of the add becomes the new top bit as the pair shifts right.
      hi_next = mul_sum[W:1];
      lo_next = {mul_sum[0], lo[W-1:1]};
    end else if (!div_diff[W]) begin
      hi_next = div_diff[W-1:0];
      lo_next = {lo[W-2:0], 1'b1};
    end else begin
      hi_next = div_shift[W-1:0];
      lo_next = {lo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer that stalls the front of the
// pipeline while iterating and pulses res_valid for one cycle with the result.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W,
  parameter int CNT_W  = MD_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic              op_is_div,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [4:0]        dest_reg,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic              res_valid,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        res_dest,
  output logic              exception
);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic                is_div_reg, neg_reg;
  logic [DATA_W-1:0]   hi_reg, lo_reg, mag_b_reg;
  logic [4:0]          tag_reg;
  logic [DATA_W-1:0]   result_reg;
  logic [4:0]          res_dest_reg;
  logic                exception_reg;

  logic [DATA_W-1:0]   hi_step, lo_step;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic                accept, div_by_zero, last_step;
  logic [2*DATA_W-1:0] prod_signed;
  logic [DATA_W-1:0]   quot_signed, fix_result;
  logic                fix_exception;

  assign accept      = (state_reg == ST_IDLE) && op_valid && !flush;
  assign div_by_zero = (op_is_div == OP_DIV) && (operand_b == '0);
  assign last_step   = (state_reg == ST_RUN) && (cnt_reg == CNT_W'(DATA_W - 1));
  assign mag_a       = operand_a[DATA_W-1] ? -operand_a : operand_a;
  assign mag_b       = operand_b[DATA_W-1] ? -operand_b : operand_b;

  md_step_unit #(.W(DATA_W)) u_step (
    .is_div  (is_div_reg),
    .hi      (hi_reg),
    .lo      (lo_reg),
    .mag_b   (mag_b_reg),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  // Sign fix-up on the final step's output so the result is ready when DONE is entered.
  always_comb begin
    prod_signed   = neg_reg ? -{hi_step, lo_step} : {hi_step, lo_step};
    quot_signed   = neg_reg ? -lo_step : lo_step;
    fix_exception = (is_div_reg == OP_MUL) &&
                    (prod_signed[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod_signed[DATA_W-1]}});
    fix_result    = (is_div_reg == OP_DIV) ? quot_signed : prod_signed[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    busy       = (state_reg != ST_IDLE);
    res_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          state_next = div_by_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        stall = 1'b1;
        if (flush)          state_next = ST_IDLE;
        else if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        res_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A pending op_valid must not stall the pipeline while reset is held.
    stall = stall & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      is_div_reg    <= 1'b0;
      neg_reg       <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      mag_b_reg     <= '0;
      tag_reg       <= '0;
      result_reg    <= '0;
      res_dest_reg  <= '0;
      exception_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg    <= '0;
      is_div_reg <= op_is_div;
      neg_reg    <= operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
      hi_reg     <= '0;
      lo_reg     <= mag_a;
      mag_b_reg  <= mag_b;
      tag_reg    <= dest_reg;
      if (div_by_zero) begin
        result_reg    <= '0;
        exception_reg <= 1'b1;
        res_dest_reg  <= dest_reg;
      end
    end else if (state_reg == ST_RUN) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      hi_reg  <= hi_step;
      lo_reg  <= lo_step;
      if (last_step && !flush) begin
        result_reg    <= fix_result;
        exception_reg <= fix_exception;
        res_dest_reg  <= tag_reg;
      end
    end
  end

  assign result    = result_reg;
  assign res_dest  = res_dest_reg;
  assign exception = exception_reg;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized and directed checks of multdiv_sequencer against a timing-level
// arithmetic model (signed 64-bit math, result due a fixed number of cycles after acceptance).
module tb_multdiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_is_div, flush;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  dest_reg;
  logic        stall, busy, res_valid, exception;
  logic [31:0] result;
  logic [4:0]  res_dest;

  int checks   = 0;
  int failures = 0;

  multdiv_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_is_div (op_is_div),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .dest_reg  (dest_reg),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .res_valid (res_valid),
    .result    (result),
    .res_dest  (res_dest),
    .exception (exception)
  );

  always #5 clk = ~clk;

  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Returns {exception, result} from plain signed arithmetic.
  function automatic logic [32:0] model_op(input logic is_div, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, r;
    logic   exc;
    sa  = $signed(a);
    sb  = $signed(b);
    exc = 1'b0;
    if (is_div) begin
      if (b == 32'd0) return {1'b1, 32'd0};
      r = sa / sb;
    end else begin
      r   = sa * sb;
      exc = (r > S_MAX) || (r < S_MIN);
    end
    return {exc, r[31:0]};
  endfunction

  // ---------------- cycle-by-cycle compare process ----------------
  int          cyc = 0;
  bit          m_pending = 0;
  int          m_done_cyc = 0;
  logic [31:0] m_exp_res, m_last_res;
  logic        m_exp_exc, m_last_exc;
  logic [4:0]  m_exp_tag, m_last_tag;
  logic        m_div;
  logic [31:0] m_a, m_b;
  int          txn = 0;

  initial begin
    m_last_res = '0; m_last_exc = 1'b0; m_last_tag = '0;
    m_exp_res  = '0; m_exp_exc  = 1'b0; m_exp_tag  = '0;
  end

  always @(negedge clk) begin
    bit          in_done;
    logic [31:0] e_res;
    logic        e_exc;
    logic [4:0]  e_tag;
    if (!rst_n) begin
      check("rst_stall", stall, 0);
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_result", result, 0);
      check("rst_res_dest", res_dest, 0);
      check("rst_exception", exception, 0);
      m_pending  = 0;
      m_last_res = '0; m_last_exc = 1'b0; m_last_tag = '0;
    end else begin
      in_done = m_pending && (cyc == m_done_cyc);
      e_res = in_done ? m_exp_res : m_last_res;
      e_exc = in_done ? m_exp_exc : m_last_exc;
      e_tag = in_done ? m_exp_tag : m_last_tag;
      check("stall", stall, ((!m_pending && op_valid && !flush) || (m_pending && !in_done)) ? 1 : 0);
      check("busy", busy, m_pending ? 1 : 0);
      check("res_valid", res_valid, in_done ? 1 : 0);
      check("result", result, e_res);
      check("exception", exception, e_exc);
      check("res_dest", res_dest, e_tag);
      if (in_done) begin
        txn++;
        $display("txn %0d: %s a=%h b=%h tag=%0d -> result=%h exc=%0b",
                 txn, m_div ? "div" : "mul", m_a, m_b, m_exp_tag, result, exception);
        m_last_res = m_exp_res; m_last_exc = m_exp_exc; m_last_tag = m_exp_tag;
        m_pending  = 0;
      end else if (m_pending && flush) begin
        m_pending = 0;
      end else if (!m_pending && op_valid && !flush) begin
        {m_exp_exc, m_exp_res} = model_op(op_is_div, operand_a, operand_b);
        m_exp_tag  = dest_reg;
        m_div = op_is_div; m_a = operand_a; m_b = operand_b;
        m_done_cyc = cyc + ((op_is_div && operand_b == 32'd0) ? 1 : 33);
        m_pending  = 1;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    op_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp_res, input logic exp_exc,
                        input int exp_lat);
    int lat, stall_cnt;
    bit seen;
    @(posedge clk); #1;
    op_valid = 1'b1; op_is_div = d; operand_a = a; operand_b = b; dest_reg = tag; flush = 1'b0;
    @(negedge clk);
    stall_cnt = stall ? 1 : 0;
    @(posedge clk); #1;
    op_valid = 1'b0; operand_a = $urandom; operand_b = $urandom; dest_reg = 5'($urandom);
    lat = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (res_valid) begin
        seen = 1;
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_result"}, result, exp_res);
        check({nm, "_exception"}, exception, exp_exc);
        check({nm, "_res_dest"}, res_dest, tag);
        check({nm, "_stall_cycles"}, stall_cnt, exp_lat);
      end else if (stall) begin
        stall_cnt++;
      end
    end
    if (!seen) check({nm, "_res_valid_timeout"}, 0, 1);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 40)) - 32'd20;
      1:       return 32'h0000_0000;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int cnt_rv, cnt_st;
    rst_n = 1'b0; op_valid = 1'b1; op_is_div = 1'b0;
    operand_a = 32'd5; operand_b = 32'd3; dest_reg = 5'd1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1; idle_inputs(); rst_n = 1'b1;

    check("model_mul_7x-3", model_op(1'b0, 32'd7, 32'hFFFF_FFFD), {1'b0, 32'hFFFF_FFEB});
    check("model_div_-100/7", model_op(1'b1, 32'hFFFF_FF9C, 32'd7), {1'b0, 32'hFFFF_FFF2});
    check("model_mul_ovf", model_op(1'b0, 32'h0001_0000, 32'h0001_0000), {1'b1, 32'h0});
    check("model_div_min", model_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 32'h8000_0000});

    run_op("mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("div_100/7", 1'b1, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0, 33);
    run_op("div_-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd17, 32'hFFFF_FFF2, 1'b0, 33);
    run_op("div_5/0", 1'b1, 32'd5, 32'd0, 5'd22, 32'd0, 1'b1, 1);
    run_op("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd30, 32'd0, 1'b1, 33);
    run_op("div_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 1'b0, 33);

    // Flush at RUN cycle 10.
    @(posedge clk); #1;
    op_valid = 1'b1; op_is_div = 1'b0; operand_a = 32'd123; operand_b = 32'd456; dest_reg = 5'd12;
    @(posedge clk); #1; op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    cnt_rv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) cnt_rv++;
    end
    check("flush_no_res_valid", cnt_rv, 0);
    run_op("mul_6x6", 1'b0, 32'd6, 32'd6, 5'd7, 32'd36, 1'b0, 33);

    // Reset at RUN cycle 5.
    @(posedge clk); #1;
    op_valid = 1'b1; op_is_div = 1'b1; operand_a = 32'd1000; operand_b = 32'd3; dest_reg = 5'd21;
    @(posedge clk); #1; op_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check("rst_now_stall", stall, 0);
    check("rst_now_busy", busy, 0);
    check("rst_now_res_valid", res_valid, 0);
    check("rst_now_result", result, 0);
    check("rst_now_res_dest", res_dest, 0);
    check("rst_now_exception", exception, 0);
    @(posedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    cnt_rv = 0; cnt_st = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) cnt_rv++;
      if (stall) cnt_st++;
    end
    check("post_rst_res_valid", cnt_rv, 0);
    check("post_rst_stall", cnt_st, 0);

    // Randomized traffic, including op_valid during RUN/DONE and flushes anywhere.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      op_valid  = ($urandom_range(0, 3) == 0);
      op_is_div = 1'($urandom_range(0, 1));
      operand_a = rand_operand();
      operand_b = rand_operand();
      dest_reg  = 5'($urandom);
      flush     = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk); #1; idle_inputs();
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
